// File: rtl/udp_dram_writer_pkg.sv
// Shared types, constants and helpers for the UDP-to-DRAM write path.
package udp_dram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_HDR,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_e;

    // Words between the ack and the DRAM address word (IP/UDP header).
    localparam int UPL_HDR_WORDS = 4;

    // Low address bits that must not wrap to zero inside one AXI burst.
    localparam logic [11:0] AXI_4K_MASK = 12'hFFF;

    // Descriptor layout for the control FIFO: {len[7:0], addr[31:0]}.
    localparam int CTRL_ADDR_LSB = 0;
    localparam int CTRL_LEN_LSB  = 32;
    localparam int CTRL_W        = 40;

    // Data FIFO word: {data[31:0], strb[3:0]}.
    localparam int FIFO_DATA_W = 36;

    // Byte strobe for the final word, indexed by the payload tail D[1:0].
    function automatic logic [3:0] last_strb(input logic [1:0] tail);
        case (tail)
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            2'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/udp_dram_writer_if.sv
// Receive stream and FIFO push bus seen by the UDP-to-DRAM writer.
interface udp_dram_writer_if;
    import udp_dram_pkg::*;

    logic                   r_req;
    logic                   r_ack;
    logic                   r_enable;
    logic [31:0]            r_data;
    logic [FIFO_DATA_W-1:0] data_in;
    logic                   data_we;
    logic [CTRL_W-1:0]      ctrl_in;
    logic                   ctrl_we;

    // Environment side: the UDP core and the FIFO sinks.
    modport master (
        output r_req, r_enable, r_data,
        input  r_ack, data_in, data_we, ctrl_in, ctrl_we
    );

    // Writer side.
    modport slave (
        input  r_req, r_enable, r_data,
        output r_ack, data_in, data_we, ctrl_in, ctrl_we
    );
endinterface

// File: rtl/burst_splitter.sv
// Tracks the open burst and emits AXI-legal descriptors one cycle after the
// last beat's data push.
module burst_splitter
    import udp_dram_pkg::*;
#(
    parameter int MAX_BURST = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [31:0]       addr_i,
    input  logic              word_i,
    input  logic              last_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_in_o,
    output logic              ctrl_we_o
);

    logic [31:0]       burst_addr_q, cur_addr_q, cur_next;
    logic [8:0]        beats_q, beats_inc;
    logic              close;
    logic              pend_q, pend_d;
    logic [CTRL_W-1:0] pend_desc_q, pend_desc_d;
    logic [CTRL_W-1:0] ctrl_in_q;
    logic              ctrl_we_q;

    // Close decision and descriptor for the word (or flush) in this cycle.
    always_comb begin
        cur_next  = cur_addr_q + 32'd4;
        beats_inc = beats_q + 9'd1;
        close     = word_i && ((beats_inc == 9'(MAX_BURST)) ||
                               ((cur_next[11:0] & AXI_4K_MASK) == 12'h000) ||
                               last_i);
        pend_d    = close || (flush_i && (beats_q != 9'd0));
        pend_desc_d = '0;
        pend_desc_d[CTRL_ADDR_LSB +: 32] = burst_addr_q;
        pend_desc_d[CTRL_LEN_LSB +: 8]   = close ? beats_q[7:0] : beats_q[7:0] - 8'd1;
    end

    // Burst bookkeeping plus a two-stage descriptor pipe that lines up
    // with the registered data push in the top level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_addr_q <= '0;
            cur_addr_q   <= '0;
            beats_q      <= '0;
            pend_q       <= 1'b0;
            pend_desc_q  <= '0;
            ctrl_in_q    <= '0;
            ctrl_we_q    <= 1'b0;
        end else begin
            if (start_i) begin
                burst_addr_q <= addr_i;
                cur_addr_q   <= addr_i;
                beats_q      <= '0;
            end else if (word_i) begin
                cur_addr_q <= cur_next;
                if (close) begin
                    burst_addr_q <= cur_next;
                    beats_q      <= '0;
                end else begin
                    beats_q <= beats_inc;
                end
            end else if (flush_i) begin
                beats_q <= '0;
            end
            pend_q      <= pend_d;
            pend_desc_q <= pend_desc_d;
            ctrl_we_q   <= pend_q;
            if (pend_q) ctrl_in_q <= pend_desc_q;
        end
    end

    assign ctrl_in_o = ctrl_in_q;
    assign ctrl_we_o = ctrl_we_q;

endmodule

// File: rtl/udp_dram_writer.sv
// Parses UDP port-0 packets ({hdr x4, addr, data...}) into DRAM write data
// and burst descriptors for the AXI writer FIFOs.
module udp_dram_writer
    import udp_dram_pkg::*;
#(
    parameter int MAX_BURST = 256,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    udp_dram_writer_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    state_e                 state_q, state_d;
    logic [1:0]             hdr_cnt_q;
    logic [15:0]            len_q;
    logic [15:0]            rem_q;
    logic [1:0]             tail_q;
    logic [FIFO_DATA_W-1:0] data_in_q;
    logic                   data_we_q;
    logic [CNT_W-1:0]       pkt_q, err_q;

    logic ack_c, busy_c, hdr_fire, hdr_last, addr_ok, addr_bad;
    logic word_fire, last_word, trunc;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.r_req) state_d = S_ACK;
            S_ACK:   state_d = S_HDR;
            S_HDR:   if (hdr_last) state_d = S_ADDR;
            S_ADDR:  if (addr_bad) state_d = S_DRAIN;
                     else if (addr_ok) state_d = S_DATA;
            S_DATA:  if (last_word) state_d = S_DRAIN;
                     else if (trunc) state_d = S_IDLE;
            S_DRAIN: if (!bus.r_enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: handshake, busy and per-cycle datapath strobes.
    always_comb begin
        ack_c     = (state_q == S_ACK);
        busy_c    = (state_q != S_IDLE);
        hdr_fire  = (state_q == S_HDR) && bus.r_enable;
        hdr_last  = hdr_fire && (hdr_cnt_q == 2'(UPL_HDR_WORDS - 1));
        addr_bad  = (state_q == S_ADDR) && bus.r_enable &&
                    ((len_q < 16'd8) || (bus.r_data[1:0] != 2'b00));
        addr_ok   = (state_q == S_ADDR) && bus.r_enable && !addr_bad;
        word_fire = (state_q == S_DATA) && bus.r_enable;
        last_word = word_fire && (rem_q == 16'd1);
        trunc     = (state_q == S_DATA) && !bus.r_enable;
    end

    // Header parsing, payload push and saturating status counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_cnt_q <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            tail_q    <= '0;
            data_in_q <= '0;
            data_we_q <= 1'b0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            if (state_q == S_IDLE) hdr_cnt_q <= '0;
            else if (hdr_fire)     hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_last) len_q <= bus.r_data[31:16];
            // W = ceil((L-4)/4) = (L-1)/4; tail D[1:0] equals L[1:0].
            if (addr_ok) begin
                rem_q  <= (len_q - 16'd1) >> 2;
                tail_q <= len_q[1:0];
            end else if (word_fire) begin
                rem_q <= rem_q - 16'd1;
            end
            data_we_q <= word_fire;
            if (word_fire)
                data_in_q <= {bus.r_data, last_word ? last_strb(tail_q) : 4'hF};
            if (last_word && (pkt_q != '1)) pkt_q <= pkt_q + 1'b1;
            if ((addr_bad || trunc) && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

    burst_splitter #(.MAX_BURST(MAX_BURST)) u_split (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (addr_ok),
        .addr_i    (bus.r_data),
        .word_i    (word_fire),
        .last_i    (last_word),
        .flush_i   (trunc),
        .ctrl_in_o (bus.ctrl_in),
        .ctrl_we_o (bus.ctrl_we)
    );

    assign bus.r_ack   = ack_c;
    assign bus.data_in = data_in_q;
    assign bus.data_we = data_we_q;
    assign busy        = busy_c;
    assign pkt_count   = pkt_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_udp_dram_writer.sv
// Directed bench for udp_dram_writer: pushes hand-built packets and checks
// FIFO pushes, descriptors and counters against hand-computed values.
module tb_udp_dram_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic [15:0] pkt_count, err_count;

    always #5 clk = ~clk;

    udp_dram_writer_if u_if ();

    udp_dram_writer #(.MAX_BURST(256), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (u_if),
        .busy      (busy),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [35:0] data_log[$];
    logic [39:0] ctrl_log[$];
    int          ctrl_dcnt[$];
    int          last_data_cyc = 0;
    int          last_ctrl_cyc = 0;

    // Cycle counter used to time-stamp FIFO pushes.
    always @(posedge clk) cyc <= cyc + 1;

    // Log FIFO pushes on the falling edge; ctrl first so its data count
    // excludes a same-cycle data push.
    always @(negedge clk) begin
        if (u_if.ctrl_we) begin
            ctrl_log.push_back(u_if.ctrl_in);
            ctrl_dcnt.push_back(data_log.size());
            last_ctrl_cyc = cyc;
        end
        if (u_if.data_we) begin
            data_log.push_back(u_if.data_in);
            last_data_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] dword(input int i);
        return 32'h11111111 * 32'(i + 1);
    endfunction

    task automatic send_word(input logic [31:0] w);
        u_if.r_enable = 1'b1;
        u_if.r_data   = w;
        tick();
    endtask

    task automatic start_pkt(input logic [15:0] len, input logic [31:0] addr);
        int t;
        t = 0;
        u_if.r_req = 1'b1;
        tick();
        while (!u_if.r_ack && t < 20) begin
            tick();
            t++;
        end
        check("ack_seen", 64'(u_if.r_ack), 64'd1);
        u_if.r_req = 1'b0;
        tick();
        check("ack_pulse", 64'(u_if.r_ack), 64'd0);
        send_word(32'hC0A80001);
        send_word(32'hC0A80002);
        send_word(32'h13881389);
        send_word({len, 16'h0000});
        send_word(addr);
    endtask

    task automatic send_pkt(input logic [15:0] len, input logic [31:0] addr, input int ndata);
        start_pkt(len, addr);
        for (int i = 0; i < ndata; i++) send_word(dword(i));
        u_if.r_enable = 1'b0;
        u_if.r_data   = '0;
        tick(6);
    endtask

    initial begin
        int d0, c0, bad;
        u_if.r_req    = 1'b0;
        u_if.r_enable = 1'b0;
        u_if.r_data   = '0;

        // Reset state.
        tick(2);
        check("rst_r_ack",   64'(u_if.r_ack),   64'd0);
        check("rst_data_we", 64'(u_if.data_we), 64'd0);
        check("rst_ctrl_we", 64'(u_if.ctrl_we), 64'd0);
        check("rst_data_in", 64'(u_if.data_in), 64'd0);
        check("rst_ctrl_in", 64'(u_if.ctrl_in), 64'd0);
        check("rst_busy",    64'(busy),         64'd0);
        check("rst_pkt",     64'(pkt_count),    64'd0);
        check("rst_err",     64'(err_count),    64'd0);
        reset_n = 1'b1;
        tick(2);

        // 1: L=20, A=0x1000, four full words, one 4-beat burst.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd20, 32'h0000_1000, 4);
        check("t1_ndata", 64'(data_log.size() - d0), 64'd4);
        for (int i = 0; i < 4; i++)
            check("t1_data", 64'(data_log[d0+i]), 64'({dword(i), 4'hF}));
        check("t1_nctrl", 64'(ctrl_log.size() - c0), 64'd1);
        check("t1_ctrl", 64'(ctrl_log[c0]), 64'h03_0000_1000);
        check("t1_ctrl_lag", 64'(last_ctrl_cyc - last_data_cyc), 64'd1);
        check("t1_pkt", 64'(pkt_count), 64'd1);
        check("t1_err", 64'(err_count), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // 2: L=11 -> D=7, two words, tail strobe 1110.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd11, 32'h0000_2000, 2);
        check("t2_ndata", 64'(data_log.size() - d0), 64'd2);
        check("t2_data0", 64'(data_log[d0]),   64'({32'h11111111, 4'hF}));
        check("t2_data1", 64'(data_log[d0+1]), 64'({32'h22222222, 4'b1110}));
        check("t2_ctrl", 64'(ctrl_log[c0]), 64'h01_0000_2000);
        check("t2_pkt", 64'(pkt_count), 64'd2);

        // 3: A=0xFF8 crosses 4 KB after two beats.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd20, 32'h0000_0FF8, 4);
        check("t3_nctrl", 64'(ctrl_log.size() - c0), 64'd2);
        check("t3_ctrl0", 64'(ctrl_log[c0]),   64'h01_0000_0FF8);
        check("t3_ctrl1", 64'(ctrl_log[c0+1]), 64'h01_0000_1000);
        check("t3_order0", 64'(ctrl_dcnt[c0] - d0),   64'd2);
        check("t3_order1", 64'(ctrl_dcnt[c0+1] - d0), 64'd4);

        // 4: 300 words from A=0 -> 256-beat burst then 44-beat burst.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd1204, 32'h0000_0000, 300);
        check("t4_ndata", 64'(data_log.size() - d0), 64'd300);
        bad = 0;
        for (int i = 0; i < 300; i++)
            if (data_log[d0+i] !== {dword(i), 4'hF}) bad++;
        check("t4_data_bad", 64'(bad), 64'd0);
        check("t4_nctrl", 64'(ctrl_log.size() - c0), 64'd2);
        check("t4_ctrl0", 64'(ctrl_log[c0]),   64'hFF_0000_0000);
        check("t4_ctrl1", 64'(ctrl_log[c0+1]), 64'h2B_0000_0400);
        check("t4_pkt", 64'(pkt_count), 64'd4);

        // 5: misaligned address and short length are dropped; next packet ok.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd20, 32'h0000_1002, 4);
        check("t5_ndata", 64'(data_log.size() - d0), 64'd0);
        check("t5_nctrl", 64'(ctrl_log.size() - c0), 64'd0);
        check("t5_err", 64'(err_count), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        send_pkt(16'd6, 32'h0000_3000, 1);
        check("t5_short_ndata", 64'(data_log.size() - d0), 64'd0);
        check("t5_short_err", 64'(err_count), 64'd2);
        send_pkt(16'd8, 32'h0000_3000, 1);
        check("t5_ok_ndata", 64'(data_log.size() - d0), 64'd1);
        check("t5_ok_data", 64'(data_log[d0]), 64'({32'h11111111, 4'hF}));
        check("t5_ok_ctrl", 64'(ctrl_log[c0]), 64'h00_0000_3000);
        check("t5_ok_pkt", 64'(pkt_count), 64'd5);

        // 6: L=36 truncated after 3 words -> partial burst closed.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd36, 32'h0000_5000, 3);
        check("t6_ndata", 64'(data_log.size() - d0), 64'd3);
        check("t6_nctrl", 64'(ctrl_log.size() - c0), 64'd1);
        check("t6_ctrl", 64'(ctrl_log[c0]), 64'h02_0000_5000);
        check("t6_err", 64'(err_count), 64'd3);
        check("t6_pkt", 64'(pkt_count), 64'd5);
        check("t6_busy", 64'(busy), 64'd0);

        // Reset pulse in the middle of DATA clears everything immediately.
        start_pkt(16'd36, 32'h0000_6000);
        send_word(dword(0));
        send_word(dword(1));
        check("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mrst_data_we", 64'(u_if.data_we), 64'd0);
        check("mrst_data_in", 64'(u_if.data_in), 64'd0);
        check("mrst_ctrl_we", 64'(u_if.ctrl_we), 64'd0);
        check("mrst_ctrl_in", 64'(u_if.ctrl_in), 64'd0);
        check("mrst_busy",    64'(busy),         64'd0);
        check("mrst_pkt",     64'(pkt_count),    64'd0);
        check("mrst_err",     64'(err_count),    64'd0);
        u_if.r_enable = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_ack",  64'(u_if.r_ack), 64'd0);

        // Recovery: a normal packet after reset.
        d0 = data_log.size(); c0 = ctrl_log.size();
        send_pkt(16'd20, 32'h0000_1000, 4);
        check("rec_ndata", 64'(data_log.size() - d0), 64'd4);
        check("rec_ctrl", 64'(ctrl_log[c0]), 64'h03_0000_1000);
        check("rec_pkt", 64'(pkt_count), 64'd1);
        check("rec_err", 64'(err_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
